// File: rtl/aes_dec.sv
`timescale 1ns/1ps
// Iterative AES-128 decryption core: forward key expansion to rk10, then ten
// inverse rounds with round keys regenerated backwards one per cycle.

module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_out = SBOX[i_in];
endmodule

module aes_dec (
  input  logic         clk,
  input  logic         resetn,
  input  logic         data_valid_in,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         ready_out,
  output logic [127:0] res_dec_out,
  output logic         res_valid_out
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] KEYEXP = 2'd1;
  localparam logic [1:0] ROUND  = 2'd2;

  logic [1:0]   fsm_q;
  logic [3:0]   rnd_q;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [127:0] r_res;
  logic         r_valid;

  function automatic logic [7:0] invAffine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Multiples 9, b, d, e are assembled from the x2/x4/x8 xtime chain.
  function automatic logic [31:0] invMixCol(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xtime(s[i]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [31:0] w_a0, w_a1, w_a2, w_a3;
  logic [31:0] w_b0, w_b1, w_b2, w_b3;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic [31:0] w_swIn, w_swRot, w_swOut, w_t;
  logic [3:0]  w_rconIdx;
  logic [127:0] w_keyNext, w_rkPrev;

  assign w_a0 = r_key[127:96];
  assign w_a1 = r_key[95:64];
  assign w_a2 = r_key[63:32];
  assign w_a3 = r_key[31:0];

  assign w_b3 = w_a3 ^ w_a2;
  assign w_b2 = w_a2 ^ w_a1;
  assign w_b1 = w_a1 ^ w_a0;

  // One SubWord unit serves both schedule directions; only one is live per state.
  assign w_swIn    = (fsm_q == ROUND) ? w_b3 : w_a3;
  assign w_rconIdx = (fsm_q == ROUND) ? (rnd_q + 4'd1) : rnd_q;
  assign w_swRot   = {w_swIn[23:0], w_swIn[31:24]};

  genvar gk;
  generate
    for (gk = 0; gk < 4; gk++) begin : g_keySbox
      aes_sbox u_sbox (
        .i_in  (w_swRot[31-8*gk -: 8]),
        .o_out (w_swOut[31-8*gk -: 8])
      );
    end
  endgenerate

  assign w_t  = w_swOut ^ {rcon(w_rconIdx), 24'h000000};
  assign w_n0 = w_a0 ^ w_t;
  assign w_n1 = w_a1 ^ w_n0;
  assign w_n2 = w_a2 ^ w_n1;
  assign w_n3 = w_a3 ^ w_n2;
  assign w_b0 = w_a0 ^ w_t;

  assign w_keyNext = {w_n0, w_n1, w_n2, w_n3};
  assign w_rkPrev  = {w_b0, w_b1, w_b2, w_b3};

  logic [127:0] w_invSub, w_ark, w_roundOut;

  // Byte index is col*4+row; row r is rotated right by r columns on the way in.
  genvar gr, gc;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        localparam int SRC = (((gc - gr + 4) % 4) * 4) + gr;
        localparam int DST = gc * 4 + gr;
        logic [7:0] w_fwdOut;
        aes_sbox u_sbox (
          .i_in  (invAffine(r_state[127-8*SRC -: 8])),
          .o_out (w_fwdOut)
        );
        assign w_invSub[127-8*DST -: 8] = invAffine(w_fwdOut);
      end
    end
  endgenerate

  assign w_ark = w_invSub ^ w_rkPrev;
  assign w_roundOut = (rnd_q == 4'd0) ? w_ark :
                      {invMixCol(w_ark[127:96]), invMixCol(w_ark[95:64]),
                       invMixCol(w_ark[63:32]),  invMixCol(w_ark[31:0])};

  // Main control: accept, expand the key forward to rk10, then unwind the rounds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= IDLE;
      rnd_q   <= 4'd0;
      r_state <= '0;
      r_key   <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (fsm_q)
        IDLE: begin
          if (data_valid_in) begin
            r_state <= data_in;
            r_key   <= key_in;
            rnd_q   <= 4'd1;
            fsm_q   <= KEYEXP;
          end
        end
        KEYEXP: begin
          r_key <= w_keyNext;
          if (rnd_q == 4'd10) begin
            r_state <= r_state ^ w_keyNext;
            rnd_q   <= 4'd9;
            fsm_q   <= ROUND;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        ROUND: begin
          r_key   <= w_rkPrev;
          r_state <= w_roundOut;
          if (rnd_q == 4'd0) begin
            r_res   <= w_roundOut;
            r_valid <= 1'b1;
            fsm_q   <= IDLE;
          end else begin
            rnd_q <= rnd_q - 4'd1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign ready_out     = (fsm_q == IDLE);
  assign res_dec_out   = r_res;
  assign res_valid_out = r_valid;
endmodule
